// File: rtl/counter_sched.sv
// counter_sched: round-robin sequencer sharing one run counter between two requesters.
// Define COUNTER_SCHED_ABORT_EN to abort a run when its owner drops req before DONE.
module counter_sched #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] len0,
    input  logic             req1,
    input  logic [WIDTH-1:0] len1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic [WIDTH-1:0] count
);
    typedef enum logic [1:0] {IDLE, GRANT, RUN, DONE} state_t;
    state_t state, state_nx;
    logic owner, owner_nx, ptr, ptr_nx, win;
    logic [WIDTH-1:0] len_q, len_nx, count_nx;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            owner <= 1'b0;
            ptr   <= 1'b0;
            len_q <= '0;
            count <= '0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            ptr   <= ptr_nx;
            len_q <= len_nx;
            count <= count_nx;
        end
    end
    always_comb begin
        win      = (req0 && req1) ? ptr : req1;
        state_nx = state;
        owner_nx = owner;
        ptr_nx   = ptr;
        len_nx   = len_q;
        count_nx = count;
        case (state)
            IDLE: if (req0 || req1) begin
                state_nx = GRANT;
                owner_nx = win;
                len_nx   = win ? len1 : len0;
                count_nx = '0;
            end
            GRANT, RUN: begin
`ifdef COUNTER_SCHED_ABORT_EN
                if (!(owner ? req1 : req0)) begin
                    state_nx = IDLE;
                    count_nx = '0;
                    ptr_nx   = ~owner;
                end else
`endif
                if (count == len_q) state_nx = DONE;
                else begin
                    state_nx = RUN;
                    count_nx = count + 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                ptr_nx   = ~owner;
            end
            default: state_nx = IDLE;
        endcase
    end
    assign busy  = state != IDLE;
    assign gnt0  = busy && !owner;
    assign gnt1  = busy && owner;
    assign done0 = (state == DONE) && !owner;
    assign done1 = (state == DONE) && owner;
endmodule

// File: doc/counter_sched.md
# counter_sched

Round-robin scheduler that shares a single WIDTH-bit run counter between two requesters. Each requester asks for a timed run of len+1 counting steps. The block arbitrates, clears and advances the counter, and reports completion with a one-cycle done pulse. It sits in front of the team's counter datapath as its sole sequencer, so requesters never drive the counter directly.

## Interface
- WIDTH, 4, width of run length inputs and count output
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- req0  in  1  requester 0 run request; level, held until done0
- len0  in  WIDTH  requester 0 terminal count, sampled at grant
- req1  in  1  requester 1 run request; level, held until done1
- len1  in  WIDTH  requester 1 terminal count, sampled at grant
- gnt0  out  1  requester 0 owns the counter
- gnt1  out  1  requester 1 owns the counter
- done0  out  1  one-cycle pulse, requester 0 run complete
- done1  out  1  one-cycle pulse, requester 1 run complete
- busy  out  1  state != IDLE
- count  out  WIDTH  current counter value

## Operation
- States: IDLE, GRANT, RUN, DONE. Internal registers:
  - owner (1 bit)
  - ptr: round-robin pointer; 0 favours req0
  - len_q (WIDTH)
- IDLE:
  - No request: stay in IDLE.
  - Any request: pick the winner.
    - If only one req is high, it wins.
    - If both are high, requester ptr wins.
  - On winning: owner <= winner, len_q <= len of the winner, count <= 0, state -> GRANT.
- GRANT / RUN:
  - If count == len_q: state -> DONE, count holds.
  - Otherwise: count <= count + 1, state -> RUN.
  - count never wraps, because it stops at len_q ≤ 2^WIDTH−1.
- DONE:
  - done[owner] is high for exactly this cycle.
  - ptr <= ~owner.
  - state -> IDLE. count holds its final value until the next grant.
- gnt[owner] is high in GRANT, RUN and DONE. At most one gnt is high at any time.
- Changes to len0/len1 after the grant are ignored.
- A req for a non-owner that rises during a run waits in IDLE arbitration.
- Reset values: state IDLE, gnt0=gnt1=0, done0=done1=0, busy=0, count=0, ptr=0, owner=0, len_q=0.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from req to gnt.
- Request latency:
  - req sampled high at edge k in IDLE → gnt high from edge k.
  - GRANT cycle: count=0.
  - RUN cycles: count=1..L.
  - DONE cycle: count=L, done high.
  - L = latched length. gnt is high for L+2 cycles.
- L=0: GRANT (count 0), then DONE; gnt is high for 2 cycles.
- At least one IDLE cycle separates consecutive grants, including back-to-back requests from the same requester.
- Reset asserted mid-run:
  - Asynchronous: all outputs go to reset values immediately.
  - No done pulse is issued.
  - Operation resumes at the first clk edge after reset rises.

## Configuration
- COUNTER_SCHED_ABORT_EN defined:
  - If req[owner] is low at an edge in GRANT or RUN, the run aborts: state -> IDLE, count <= 0, ptr <= ~owner, no done pulse.
  - An abort does not apply in DONE; the done pulse still fires there.
- COUNTER_SCHED_ABORT_EN not defined:
  - req[owner] is ignored after the grant.
  - Every granted run completes through DONE.

## Test plan
- Reset, then req0=1, len0=3: gnt0 high for 5 cycles, count 0,1,2,3,3, done0 pulses on the 5th cycle, busy falls with gnt0.
- req0=req1=1 after reset, len0=1, len1=2:
  - gnt0 first (3 cycles, done0).
  - 1 IDLE cycle.
  - gnt1 (4 cycles, done1).
  - Then gnt0 again if req0 is still held; ptr alternates.
- req1=1 with len1=0: gnt1 high 2 cycles, count stays 0, done1 on the 2nd cycle.
- len0=15, reset driven low at count=7: gnt0, busy and count drop to 0 asynchronously with no done0; after release, req0 is re-granted from count 0.
- Drop req0 at count=2 of a len0=5 run:
  - With COUNTER_SCHED_ABORT_EN: IDLE next cycle, count=0, no done0, and the next grant goes to req1 if it is pending.
  - Without the macro: the run completes to 5 and done0 pulses.
